med_window_ctrl: RTL and testbench

Sequencer for the 3×3 median datapath (`med_9`). On a start pulse it scans a stored IMG_W×IMG_H image in raster order. For each output pixel it fetches the nine window taps from image memory, substituting zero at the borders, and streams them to `med_9` with the tap count and the valid strobe that engine expects. It then captures the median and writes it to the result memory under a ready/valid handshake.

---
 rtl/med_ctrl_pkg.sv | 35 +++
 rtl/med_window_ctrl_tap_gen.sv | 41 ++++
 rtl/med_window_ctrl.sv | 155 +++++++++++++++
 tb/tb_med_window_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/med_ctrl_pkg.sv
// Shared types and constants for the 3x3 median window sequencer.
// Tap k walks the window row-major; offsets are biased by +1.
package med_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int         DATA_W_DEF     = 14;
  localparam logic [3:0] MED_COUNT_IDLE = 4'd15;
  localparam logic [3:0] TAP_LAST       = 4'd8;
  localparam logic [1:0] TAP_LO         = 2'd0;
  localparam logic [1:0] TAP_CENTER     = 2'd1;
  localparam logic [1:0] TAP_HI         = 2'd2;

  function automatic logic [1:0] tap_dr(input logic [3:0] k);
    if (k < 4'd3)      return TAP_LO;
    else if (k < 4'd6) return TAP_CENTER;
    else               return TAP_HI;
  endfunction

  function automatic logic [1:0] tap_dc(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return TAP_LO;
      4'd1, 4'd4, 4'd7: return TAP_CENTER;
      default:          return TAP_HI;
    endcase
  endfunction

endpackage

// File: rtl/med_window_ctrl_tap_gen.sv
// Window tap address generator with border detection.
// Padded taps report address 0 so nothing underflows downstream.
module med_tap_gen
  import med_ctrl_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H),
  parameter int RW     = $clog2(IMG_H),
  parameter int CW     = $clog2(IMG_W)
) (
  input  logic [RW-1:0]     i_row,
  input  logic [CW-1:0]     i_col,
  input  logic [3:0]        i_k,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_pad
);

  logic [1:0]        w_dr;
  logic [1:0]        w_dc;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  assign w_dr = tap_dr(i_k);
  assign w_dc = tap_dc(i_k);

  assign o_pad =
    (w_dr == TAP_LO && i_row == '0) ||
    (w_dr == TAP_HI && i_row == RW'(IMG_H-1)) ||
    (w_dc == TAP_LO && i_col == '0) ||
    (w_dc == TAP_HI && i_col == CW'(IMG_W-1));

  assign w_row = ADDR_W'(i_row) + ADDR_W'(w_dr)
               - ADDR_W'(TAP_CENTER);
  assign w_col = ADDR_W'(i_col) + ADDR_W'(w_dc)
               - ADDR_W'(TAP_CENTER);

  assign o_addr = o_pad ? '0
                : w_row * ADDR_W'(IMG_W) + w_col;

endmodule

// File: rtl/med_window_ctrl.sv
// Raster-scan sequencer feeding 3x3 windows to med_9
// and writing each median back under a ready/valid handshake.
module med_window_ctrl
  import med_ctrl_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] med_data,
  output logic [3:0]        med_count,
  output logic              med_valid,
  input  logic [DATA_W-1:0] med_result,
  input  logic              med_result_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_k;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic              r_stv;
  logic [3:0]        r_stk;
  logic              r_pad;
  logic [DATA_W-1:0] r_wr_data;
  logic              w_pad;
  logic [ADDR_W-1:0] w_tap_addr;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_accept;

  med_tap_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .RW     (RW),
    .CW     (CW)
  ) u_tap (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_k    (r_k),
    .o_addr (w_tap_addr),
    .o_pad  (w_pad)
  );

  assign w_last_col = (r_col == CW'(IMG_W-1));
  assign w_last_row = (r_row == RW'(IMG_H-1));
  assign w_accept   = (r_state == S_WRITE) && wr_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state and control strobes
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_ren  = 1'b0;
    mem_addr = '0;
    wr_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        mem_ren  = !w_pad;
        mem_addr = w_tap_addr;
        if (r_k == TAP_LAST) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (med_result_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (wr_ready)
          w_next = (w_last_col && w_last_row) ? S_DONE
                 : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // tap counter, scan position, stream stage and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_stv     <= 1'b0;
      r_stk     <= '0;
      r_pad     <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_stv <= (r_state == S_FETCH);
      r_stk <= r_k;
      r_pad <= w_pad;
      if (r_state == S_FETCH)
        r_k <= (r_k == TAP_LAST) ? 4'd0 : r_k + 4'd1;
      if (r_state == S_IDLE && start) begin
        r_row <= '0;
        r_col <= '0;
      end
      if (r_state == S_WAIT && med_result_valid)
        r_wr_data <= med_result;
      if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign med_data  = (r_stv && !r_pad) ? mem_rdata : '0;
  assign med_count = !r_stv ? MED_COUNT_IDLE
                   : (r_stk == TAP_LAST) ? 4'd0
                   : r_stk + 4'd1;
  assign med_valid = r_stv && (r_stk == TAP_LAST);
  assign wr_addr   = ADDR_W'(r_row) * ADDR_W'(IMG_W)
                   + ADDR_W'(r_col);
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_med_window_ctrl.sv
// Bench for med_window_ctrl: 8x8 image with pixel = address,
// behavioural med_9 with 4-cycle result latency.
module tb_med_window_ctrl;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] med_data;
  logic [3:0]        med_count;
  logic              med_valid;
  logic [DATA_W-1:0] med_result;
  logic              med_result_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  med_window_ctrl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .mem_ren          (mem_ren),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .med_data         (med_data),
    .med_count        (med_count),
    .med_valid        (med_valid),
    .med_result       (med_result),
    .med_result_valid (med_result_valid),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_ready         (wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int wr_count;
  int first_addr;
  int wr_log [64];
  int tr_cnt [0:1100];
  int tr_val [0:1100];
  int tr_dat [0:1100];
  int tr_ren [0:1100];
  int tr_addr[0:1100];

  typedef struct {
    int addr;
    int exp;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int med9(input int v [9]);
    int a [9];
    int t;
    a = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t      = a[j];
          a[j]   = a[j+1];
          a[j+1] = t;
        end
    return a[4];
  endfunction

  function automatic int ref_med(input int p);
    int v [9];
    int r;
    int c;
    int rr;
    int cc;
    r = p / IMG_W;
    c = p % IMG_W;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (rr < 0 || rr >= IMG_H || cc < 0 || cc >= IMG_W)
        v[k] = 0;
      else
        v[k] = rr * IMG_W + cc;
    end
    return med9(v);
  endfunction

  // image memory: pixel value equals its address
  always @(posedge clk)
    if (mem_ren) mem_rdata <= DATA_W'(mem_addr);

  // engine model: gathers taps, answers 4 cycles after tap 8
  int eng_taps [9];
  int eng_pend;
  initial begin
    eng_pend         = 0;
    med_result       = '0;
    med_result_valid = 1'b0;
    mem_rdata        = '0;
  end
  always @(posedge clk) begin
    med_result_valid <= 1'b0;
    if (med_count != 4'd15)
      eng_taps[(med_count == 4'd0) ? 8
               : int'(med_count) - 1] = int'(med_data);
    if (med_valid) begin
      med_result <= DATA_W'(med9(eng_taps));
      eng_pend = 3;
    end else if (eng_pend > 0) begin
      if (eng_pend == 1) med_result_valid <= 1'b1;
      eng_pend--;
    end
  end

  // result sink monitor
  always @(negedge clk) begin
    #2;
    if (rst_n && wr_en && wr_ready) begin
      if (wr_count == 0) first_addr = int'(wr_addr);
      wr_log[wr_addr] = int'(wr_data);
      chk("wr_data_ref", int'(wr_data),
          ref_med(int'(wr_addr)));
      wr_count++;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_mem_ren"},   mem_ren, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_med_data"},  med_data, 0);
    chk({tag, "_med_count"}, med_count, 15);
    chk({tag, "_med_valid"}, med_valid, 0);
    chk({tag, "_wr_en"},     wr_en, 0);
    chk({tag, "_wr_addr"},   wr_addr, 0);
    chk({tag, "_wr_data"},   wr_data, 0);
  endtask

  int done_t;
  int got;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    wr_count = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    wr_ready = 1'b1;
    tbl[0] = '{addr: 0,  exp: 0};
    tbl[1] = '{addr: 9,  exp: 9};
    tbl[2] = '{addr: 28, exp: 28};
    tbl[3] = '{addr: 63, exp: 0};
    tbl[4] = '{addr: 10, exp: 10};

    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // run 1: full scan, start re-pulsed mid-scan and on DONE
    wr_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_t = -1;
    for (int t = 1; t <= 1100 && done_t < 0; t++) begin
      tr_cnt[t]  = int'(med_count);
      tr_val[t]  = int'(med_valid);
      tr_dat[t]  = int'(med_data);
      tr_ren[t]  = int'(mem_ren);
      tr_addr[t] = int'(mem_addr);
      if (t == 1) chk("busy_after_start", busy, 1);
      start = (t == 300);
      if (done) begin
        done_t = t;
        start  = 1'b1;
        chk("busy_low_on_done", busy, 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (done_t < 0) chk("run1_timeout", 0, 1);
    else chk("done_latency_ok",
             int'(done_t >= 959 && done_t <= 961), 1);
    chk("idle_after_done", busy, 0);
    repeat (3) @(negedge clk);
    chk("start_on_done_ignored", busy, 0);
    chk("run1_writes", wr_count, 64);

    for (int i = 0; i < 5; i++)
      chk("tbl_result", wr_log[tbl[i].addr], tbl[i].exp);

    for (int i = 0; i < 9; i++) begin
      chk("p9_count", tr_cnt[137+i], (i + 1) % 9);
      chk("p9_valid", tr_val[137+i], (i == 8) ? 1 : 0);
    end
    chk("p9_idle_before", tr_cnt[136], 15);
    chk("p9_idle_after", tr_cnt[146], 15);
    chk("p9_center_data", tr_dat[141], 9);
    for (int i = 0; i < 3; i++) begin
      chk("p3_pad_ren", tr_ren[46+i], 0);
      chk("p3_pad_data", tr_dat[47+i], 0);
    end
    chk("p3_tap3_ren", tr_ren[49], 1);
    chk("p3_tap3_addr", tr_addr[49], 2);
    chk("p3_tap8_addr", tr_addr[54], 12);
    chk("p0_first_ren", tr_ren[5], 1);
    chk("p0_first_addr", tr_addr[5], 0);

    // run 2: backpressure on pixel 10
    wr_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && wr_count < 10; i++)
      @(negedge clk);
    wr_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(negedge clk);
      if (wr_en) got = 1;
    end
    chk("bp_reached_write", got, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_wr_en", wr_en, 1);
      chk("bp_wr_addr", wr_addr, 10);
      chk("bp_wr_data", wr_data, 10);
      chk("bp_no_ren", mem_ren, 0);
      if (i < 4) @(negedge clk);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", wr_en, 0);
    chk("bp_next_ren", mem_ren, 1);
    chk("bp_next_addr", mem_addr, 2);
    chk("bp_count", wr_count, 11);
    got = 0;
    for (int i = 0; i < 1200 && got == 0; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("run2_done", got, 1);
    chk("run2_writes", wr_count, 64);

    // run 3: start in the IDLE cycle right after DONE
    @(negedge clk);
    chk("idle_before_restart", busy, 0);
    wr_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", busy, 1);
    got = 0;
    for (int i = 0; i < 500 && got == 0; i++) begin
      @(negedge clk);
      if (med_valid && wr_count == 20) got = 1;
    end
    chk("reached_pix20_drain", got, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_write_after_rst", wr_en, 0);
    end
    chk("run3_writes", wr_count, 20);

    // run 4: fresh scan starts at address 0
    wr_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && wr_count < 1; i++)
      @(negedge clk);
    chk("run4_got_write", int'(wr_count >= 1), 1);
    chk("run4_first_addr", first_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
